// File: rtl/xfer_pkg.sv
// xfer_pkg: shared state and status encodings for the burst transfer controller
package xfer_pkg;
    typedef enum logic [1:0] {IDLE, REQ, XFER, INT} state_t;
    typedef enum logic [1:0] {ST_NONE, ST_DONE, ST_ABORT, ST_TIMEOUT} status_t;
endpackage

// File: rtl/xfer_burst_ctrl_if.sv
// xfer_burst_ctrl_if: source valid/ready stream plus memory write port
interface xfer_burst_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              src_valid;
    logic              src_ready;
    logic [DATA_W-1:0] src_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    modport master(input src_valid, src_data, output src_ready, mem_we, mem_addr, mem_wdata);
    modport slave(output src_valid, src_data, input src_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/xfer_word_counter.sv
// xfer_word_counter: up-counter with clear, enable and terminal-count compare
module xfer_word_counter #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] count,
    output logic         tc
);
    always_ff @(posedge clock or posedge reset)
        if (reset) count <= '0;
        else if (clr) count <= '0;
        else if (en) count <= count + W'(1);
    assign tc = count == term;
endmodule

// File: rtl/xfer_burst_ctrl.sv
// xfer_burst_ctrl: moves len words from a valid/ready source into memory, then raises irq with a status
module xfer_burst_ctrl
    import xfer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 10,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ack,
    output logic              init,
    output logic              busy,
    output logic              irq,
    output logic [1:0]        irq_status,
    output logic [LEN_W-1:0]  words_done,
    xfer_burst_ctrl_if.master bus
);
    localparam int SW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] base_q;
    logic [SW-1:0]     stall;
    logic              hs, done, timeout, words_tc, stall_tc;
    assign bus.src_ready = state == XFER && !abort;
    assign hs = bus.src_valid && bus.src_ready;
    assign done = hs && words_tc;
    // fires on the TIMEOUT_CYC-th consecutive stall cycle
    assign timeout = TIMEOUT_CYC != 0 && !bus.src_valid && stall_tc;
    xfer_word_counter #(.W(LEN_W)) u_words (
        .clock(clock), .reset(reset), .clr(state == IDLE && start), .en(hs),
        .term(len_q - LEN_W'(1)), .count(words_done), .tc(words_tc)
    );
    // saturates so a disabled timeout never wraps
    xfer_word_counter #(.W(SW)) u_stall (
        .clock(clock), .reset(reset), .clr(hs || state != XFER),
        .en(!bus.src_valid && stall != {SW{1'b1}}),
        .term(SW'(TIMEOUT_CYC - 1)), .count(stall), .tc(stall_tc)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            init <= 1'b0;
            busy <= 1'b0;
            irq <= 1'b0;
            irq_status <= ST_NONE;
            len_q <= '0;
            base_q <= '0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= hs;
            if (hs) begin
                bus.mem_addr <= base_q + ADDR_W'(words_done);
                bus.mem_wdata <= DATA_W'(bus.src_data);
            end
            case (state)
                IDLE: if (start) begin
                    state <= REQ;
                    init <= 1'b1;
                    busy <= 1'b1;
                end
                REQ: begin
                    len_q <= len;
                    base_q <= base_addr;
                    if (abort) begin
                        state <= INT;
                        init <= 1'b0;
                        irq <= 1'b1;
                        irq_status <= ST_ABORT;
                    end else if (!start) begin
                        init <= 1'b0;
                        state <= len == '0 ? INT : XFER;
                        irq <= len == '0;
                        irq_status <= len == '0 ? ST_DONE : ST_NONE;
                    end
                end
                XFER: if (abort || done || timeout) begin
                    state <= INT;
                    irq <= 1'b1;
                    irq_status <= abort ? ST_ABORT : done ? ST_DONE : ST_TIMEOUT;
                end
                INT: if (ack) begin
                    state <= IDLE;
                    busy <= 1'b0;
                    irq <= 1'b0;
                    irq_status <= ST_NONE;
                end
            endcase
        end
endmodule

// File: tb/tb_xfer_burst_ctrl.sv
// tb_xfer_burst_ctrl: scenario tasks plus a write scoreboard for xfer_burst_ctrl
module tb_xfer_burst_ctrl;
    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    logic clock = 0, reset = 1;
    logic start = 0, abort = 0, ack = 0, init, busy, irq;
    logic [9:0] len = 0, base_addr = 0, words_done;
    logic [1:0] irq_status;
    logic b_start = 0, b_abort = 0, b_ack = 0, b_init, b_busy, b_irq;
    logic [9:0] b_len = 0, b_words_done;
    logic [1:0] b_status;
    int checks = 0, errors = 0, cyc = 0;
    wr_t sb[$];

    xfer_burst_ctrl_if #(.DATA_W(8), .ADDR_W(10)) a_bus ();
    xfer_burst_ctrl_if #(.DATA_W(8), .ADDR_W(10)) b_bus ();

    xfer_burst_ctrl #(.TIMEOUT_CYC(8)) u_a (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .len(len),
        .base_addr(base_addr), .ack(ack), .init(init), .busy(busy), .irq(irq),
        .irq_status(irq_status), .words_done(words_done), .bus(a_bus)
    );
    xfer_burst_ctrl #(.TIMEOUT_CYC(0)) u_b (
        .clock(clock), .reset(reset), .start(b_start), .abort(b_abort), .len(b_len),
        .base_addr(10'h000), .ack(b_ack), .init(b_init), .busy(b_busy), .irq(b_irq),
        .irq_status(b_status), .words_done(b_words_done), .bus(b_bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // every observed write must match the oldest expected one, in the expected cycle
    always @(negedge clock) begin
        if (a_bus.mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%h data=%h cyc=%0d", a_bus.mem_addr, a_bus.mem_wdata, cyc);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (a_bus.mem_addr !== e.addr || a_bus.mem_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                             a_bus.mem_addr, a_bus.mem_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            checks++;
            errors++;
            $display("FAIL write_missing got none expected addr=%h cyc=%0d", sb[0].addr, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [9:0] a, input logic [7:0] d);
        sb.push_back('{a, d, cyc + 1});
    endtask

    task automatic launch(input logic [9:0] l, input logic [9:0] b);
        len = l;
        base_addr = b;
        start = 1;
        tick();
        tick();
        start = 0;
        tick();
    endtask

    task automatic ack_irq();
        ack = 1;
        tick();
        ack = 0;
    endtask

    task automatic send(input logic [9:0] b, input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            a_bus.src_valid = 1;
            a_bus.src_data = d;
            push(b + 10'(i), d);
            tick();
        end
        a_bus.src_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({init, busy, irq, irq_status, a_bus.mem_we, a_bus.src_ready} !== '0 ||
            a_bus.mem_addr !== '0 || a_bus.mem_wdata !== '0 || words_done !== '0) begin
            errors++;
            $display("FAIL reset_state init=%b busy=%b irq=%b st=%b we=%b rdy=%b addr=%h wd=%h wdone=%0d required all 0",
                     init, busy, irq, irq_status, a_bus.mem_we, a_bus.src_ready, a_bus.mem_addr, a_bus.mem_wdata, words_done);
        end
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_basic();
        len = 4;
        base_addr = 10'h3FE;
        start = 1;
        a_bus.src_valid = 1;
        a_bus.src_data = 8'hA5;
        tick();
        checks++;
        if (init !== 1 || busy !== 1 || a_bus.src_ready !== 0) begin
            errors++;
            $display("FAIL req_state init=%b busy=%b rdy=%b required 1 1 0", init, busy, a_bus.src_ready);
        end
        tick();
        start = 0;
        checks++;
        if (init !== 1) begin
            errors++;
            $display("FAIL req_hold init=%b required 1", init);
        end
        tick();
        checks++;
        if (init !== 0 || a_bus.src_ready !== 1) begin
            errors++;
            $display("FAIL xfer_entry init=%b rdy=%b required 0 1", init, a_bus.src_ready);
        end
        send(10'h3FE, 4);
        checks++;
        if (irq !== 1 || irq_status !== 2'b01 || words_done !== 4 || busy !== 1) begin
            errors++;
            $display("FAIL basic_done irq=%b st=%b wdone=%0d busy=%b required 1 01 4 1", irq, irq_status, words_done, busy);
        end
        ack_irq();
        checks++;
        if (irq !== 0 || irq_status !== 2'b00 || busy !== 0 || words_done !== 4) begin
            errors++;
            $display("FAIL basic_ack irq=%b st=%b busy=%b wdone=%0d required 0 00 0 4", irq, irq_status, busy, words_done);
        end
    endtask

    task automatic test_toggle();
        logic [4:0] pat = 5'b10101;
        logic [7:0] d;
        int n = 0;
        launch(3, 10'h040);
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            a_bus.src_valid = pat[i];
            a_bus.src_data = d;
            if (pat[i]) begin
                push(10'h040 + 10'(n), d);
                n++;
            end
            checks++;
            if (a_bus.src_ready !== 1) begin
                errors++;
                $display("FAIL toggle_ready step=%0d rdy=%b required 1", i, a_bus.src_ready);
            end
            tick();
        end
        a_bus.src_valid = 0;
        checks++;
        if (irq !== 1 || irq_status !== 2'b01 || words_done !== 3) begin
            errors++;
            $display("FAIL toggle_done irq=%b st=%b wdone=%0d required 1 01 3", irq, irq_status, words_done);
        end
        ack_irq();
    endtask

    task automatic test_timeout();
        launch(5, 10'h100);
        send(10'h100, 2);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (irq !== 0 || busy !== 1) begin
                errors++;
                $display("FAIL timeout_early stall=%0d irq=%b busy=%b required 0 1", k, irq, busy);
            end
            tick();
        end
        checks++;
        if (irq !== 1 || irq_status !== 2'b11 || words_done !== 2) begin
            errors++;
            $display("FAIL timeout irq=%b st=%b wdone=%0d required 1 11 2", irq, irq_status, words_done);
        end
        ack_irq();
    endtask

    task automatic test_abort();
        launch(6, 10'h200);
        send(10'h200, 2);
        a_bus.src_valid = 1;
        a_bus.src_data = 8'h77;
        abort = 1;
        #1;
        checks++;
        if (a_bus.src_ready !== 0) begin
            errors++;
            $display("FAIL abort_ready rdy=%b required 0", a_bus.src_ready);
        end
        tick();
        abort = 0;
        a_bus.src_valid = 0;
        checks++;
        if (irq !== 1 || irq_status !== 2'b10 || words_done !== 2) begin
            errors++;
            $display("FAIL abort irq=%b st=%b wdone=%0d required 1 10 2", irq, irq_status, words_done);
        end
        ack_irq();
    endtask

    task automatic test_zero();
        launch(0, 10'h300);
        checks++;
        if (irq !== 1 || irq_status !== 2'b01 || words_done !== 0 || a_bus.src_ready !== 0) begin
            errors++;
            $display("FAIL zero_len irq=%b st=%b wdone=%0d rdy=%b required 1 01 0 0", irq, irq_status, words_done, a_bus.src_ready);
        end
        ack_irq();
    endtask

    task automatic test_async_reset();
        launch(4, 10'h010);
        send(10'h010, 1);
        @(negedge clock);
        a_bus.src_valid = 1;
        a_bus.src_data = 8'h5A;
        #2 reset = 1;
        #1;
        checks++;
        if ({init, busy, irq, irq_status, a_bus.mem_we, a_bus.src_ready} !== '0 ||
            a_bus.mem_addr !== '0 || a_bus.mem_wdata !== '0 || words_done !== '0) begin
            errors++;
            $display("FAIL async_reset init=%b busy=%b irq=%b st=%b we=%b rdy=%b addr=%h wd=%h wdone=%0d required all 0",
                     init, busy, irq, irq_status, a_bus.mem_we, a_bus.src_ready, a_bus.mem_addr, a_bus.mem_wdata, words_done);
        end
        tick();
        reset = 0;
        a_bus.src_valid = 0;
        tick();
        launch(2, 10'h3FF);
        send(10'h3FF, 2);
        checks++;
        if (irq !== 1 || irq_status !== 2'b01 || words_done !== 2) begin
            errors++;
            $display("FAIL after_reset irq=%b st=%b wdone=%0d required 1 01 2", irq, irq_status, words_done);
        end
        ack_irq();
    endtask

    task automatic test_no_timeout();
        int bad = 0;
        b_len = 5;
        b_start = 1;
        tick();
        tick();
        b_start = 0;
        tick();
        b_bus.src_valid = 0;
        for (int k = 0; k < 1000; k++) begin
            if (b_irq || b_init || b_bus.mem_we || !b_busy) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || b_bus.src_ready !== 1 || b_words_done !== 0) begin
            errors++;
            $display("FAIL no_timeout bad_cycles=%0d rdy=%b wdone=%0d required 0 1 0", bad, b_bus.src_ready, b_words_done);
        end
        b_abort = 1;
        tick();
        b_abort = 0;
        checks++;
        if (b_irq !== 1 || b_status !== 2'b10) begin
            errors++;
            $display("FAIL no_timeout_abort irq=%b st=%b required 1 10", b_irq, b_status);
        end
        b_ack = 1;
        tick();
        b_ack = 0;
    endtask

    initial begin
        a_bus.src_valid = 0;
        a_bus.src_data = 0;
        b_bus.src_valid = 0;
        b_bus.src_data = 0;
        test_reset();
        test_basic();
        test_toggle();
        test_timeout();
        test_abort();
        test_zero();
        test_async_reset();
        test_no_timeout();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xfer_burst_ctrl.md
Name: xfer_burst_ctrl

Overview:
- Parametrised successor to the single-shot flash transfer controller.
- Moves a programmable number of words from a valid/ready source into memory. Generates write address and data itself instead of relying on an external carry-out counter.
- Adds abort, a source-stall timeout, and a status code reported with the interrupt.
- Sits between the flash/peripheral data interface and the local write port of the memory.

Parameters:
- DATA_W, 8, width of source and memory data.
- ADDR_W, 10, width of memory address.
- LEN_W, 10, width of transfer length (max words 2^LEN_W - 1).
- TIMEOUT_CYC, 256, consecutive stall cycles in XFER before timeout; 0 disables the timeout.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level request; rising then falling sequence launches a transfer
- abort  in  1  terminate current transfer
- len  in  LEN_W  number of words, sampled in REQ
- base_addr  in  ADDR_W  first write address, sampled in REQ
- src_valid  in  1  source word available
- src_data  in  DATA_W  source word
- src_ready  out  1  controller accepts word this cycle
- init  out  1  high in REQ (interface request)
- busy  out  1  high in any state other than IDLE
- mem_we  out  1  registered write strobe
- mem_addr  out  ADDR_W  registered write address
- mem_wdata  out  DATA_W  registered write data
- irq  out  1  interrupt, held until ack
- irq_status  out  2  00 none, 01 DONE, 10 ABORT, 11 TIMEOUT
- ack  in  1  interrupt acknowledge
- words_done  out  LEN_W  words accepted in current/last transfer

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE.
  - src_ready, init, busy, mem_we, irq = 0; mem_addr, mem_wdata, words_done = 0; irq_status = 00.
  - Any pending write is dropped.
- State IDLE:
  - start=1 -> REQ; words_done is cleared on this transition.
- State REQ:
  - init=1.
  - len and base_addr are latched every cycle while in REQ.
  - start=0 -> XFER, or -> INT with status DONE if the latched len=0.
  - abort=1 -> INT with status ABORT. abort has priority over start.
- State XFER:
  - src_ready = (state==XFER) & ~abort. This is combinational, and is the only combinational output.
  - Handshake = src_valid & src_ready. On handshake at cycle t:
    - At t+1: mem_we=1, mem_addr = base + words_done(t), mem_wdata = src_data(t).
    - words_done increments at t+1.
    - Back-to-back handshakes give one write per cycle.
  - mem_we is 0 in every cycle not following a handshake.
  - Address arithmetic is modulo 2^ADDR_W (wraps silently).
  - When the handshake completes the last word (words_done == len-1), next state is INT with status DONE. The final mem_we and irq rise in the same cycle.
  - abort=1 -> INT with status ABORT. No word is accepted in the abort cycle. A write from the previous cycle's handshake still completes.
  - Stall counter:
    - Counts cycles with src_valid=0 in XFER.
    - Cleared on each handshake and on entry to XFER.
    - When the counter reaches TIMEOUT_CYC, next state is INT with status TIMEOUT.
- State INT:
  - irq=1 and irq_status held.
  - start and abort are ignored.
  - ack=1 -> IDLE. irq and irq_status clear in the following cycle. ack held high across cycles has no further effect.
  - ack outside INT is ignored.
- Latency: start falling edge to first src_ready is 1 cycle. Handshake to write is 1 cycle.
- words_done holds its final value in INT and IDLE until the next IDLE->REQ transition.

Decomposition:
- Shared package xfer_pkg:
  - State encoding: IDLE, REQ, XFER, INT as 2-bit localparams.
  - Status codes ST_NONE, ST_DONE, ST_ABORT, ST_TIMEOUT.
- One sub-module: xfer_word_counter.
  - Parametrised up-counter with clear, enable, and terminal-count compare against len-1.
  - Used for words_done.
  - A second instance, with terminal count TIMEOUT_CYC, serves as the stall counter.

Test Plan:
- len=4, base=0x3FE, src_valid always 1:
  - start 1 for 2 cycles then 0.
  - Expect init high only in REQ, and 4 consecutive writes to 0x3FE, 0x3FF, 0x000, 0x001 carrying the source data.
  - irq rises with the 4th mem_we, irq_status=01, words_done=4.
  - ack -> irq low next cycle, busy low.
- len=3, src_valid toggling 1,0,1,0,1: expect exactly 3 writes, each one cycle after its handshake; no mem_we in gap cycles.
- TIMEOUT_CYC=8, len=5, 2 words delivered then src_valid=0:
  - Expect irq with status 11 after 8 stall cycles, and words_done=2.
  - Repeat with TIMEOUT_CYC=0: no timeout after 1000 cycles.
- abort asserted in the same cycle as src_valid during word 3 of len=6:
  - Expect src_ready=0 that cycle and status 10.
  - words_done=2, with word 2's write still issued.
- len=0: expect REQ -> INT, status 01, no mem_we.
- Asynchronous reset pulse in mid-XFER between clock edges:
  - All outputs zero immediately and state IDLE.
  - A fresh transfer afterwards completes normally.
